// File: rtl/vga_sync_gen.sv
// vga_sync_gen: 640x480@60 VGA timing from the 25 MHz wizard clock.
// The display stays blanked until the wizard lock is stable.
module vga_sync_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter bit SYNC_POL = 1'b0
) (
  input  logic       clk25,
  input  logic       reset_n,
  input  logic       locked,
  output logic       hsync,
  output logic       vsync,
  output logic       video_on,
  output logic [9:0] pixel_x,
  output logic [9:0] pixel_y,
  output logic       line_start,
  output logic       frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  generate
    if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_size_chk
      $error("vga_sync_gen: timing totals exceed 10-bit counters");
    end
  endgenerate

  localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS  = 10'(H_ACTIVE);
  localparam logic [9:0] V_VIS  = 10'(V_ACTIVE);
  localparam logic [9:0] HS_BEG = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_END = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [9:0] VS_BEG = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_END = 10'(V_ACTIVE + V_FP + V_SYNC - 1);

  typedef enum logic {
    WAIT_LOCK = 1'b0,
    RUN       = 1'b1
  } state_t;

  state_t     state;
  state_t     state_nxt;
  logic       sync_q1;
  logic       lock_s;
  logic [9:0] h_cnt;
  logic [9:0] v_cnt;
  logic       advance;
  logic       h_wrap;
  logic       v_wrap;

  logic       hsync_nxt;
  logic       vsync_nxt;
  logic       video_nxt;
  logic [9:0] px_nxt;
  logic [9:0] py_nxt;
  logic       ls_nxt;
  logic       fs_nxt;

  // locked comes from the wizard's own domain
  always_ff @(posedge clk25 or negedge reset_n) begin
    if (!reset_n) begin
      sync_q1 <= 1'b0;
      lock_s  <= 1'b0;
    end else begin
      sync_q1 <= locked;
      lock_s  <= sync_q1;
    end
  end

  always_ff @(posedge clk25 or negedge reset_n) begin
    if (!reset_n) state <= WAIT_LOCK;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      WAIT_LOCK: if (lock_s)  state_nxt = RUN;
      RUN:       if (!lock_s) state_nxt = WAIT_LOCK;
    endcase
  end

  assign advance = (state == RUN) && lock_s;
  assign h_wrap  = (h_cnt == H_LAST);
  assign v_wrap  = (v_cnt == V_LAST);

  // counters sit at 0 until running, so entering RUN starts at (0,0)
  always_ff @(posedge clk25 or negedge reset_n) begin
    if (!reset_n) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (!advance) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else begin
      h_cnt <= h_wrap ? 10'd0 : h_cnt + 10'd1;
      if (h_wrap) v_cnt <= v_wrap ? 10'd0 : v_cnt + 10'd1;
    end
  end

  always_comb begin
    hsync_nxt = ~SYNC_POL;
    vsync_nxt = ~SYNC_POL;
    video_nxt = 1'b0;
    px_nxt    = '0;
    py_nxt    = '0;
    ls_nxt    = 1'b0;
    fs_nxt    = 1'b0;
    if (state == RUN) begin
      if (h_cnt >= HS_BEG && h_cnt <= HS_END) hsync_nxt = SYNC_POL;
      if (v_cnt >= VS_BEG && v_cnt <= VS_END) vsync_nxt = SYNC_POL;
      video_nxt = (h_cnt < H_VIS) && (v_cnt < V_VIS);
      if (video_nxt) begin
        px_nxt = h_cnt;
        py_nxt = v_cnt;
      end
      ls_nxt = (h_cnt == 10'd0);
      fs_nxt = (h_cnt == 10'd0) && (v_cnt == 10'd0);
    end
  end

  always_ff @(posedge clk25 or negedge reset_n) begin
    if (!reset_n) begin
      hsync       <= ~SYNC_POL;
      vsync       <= ~SYNC_POL;
      video_on    <= 1'b0;
      pixel_x     <= '0;
      pixel_y     <= '0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      hsync       <= hsync_nxt;
      vsync       <= vsync_nxt;
      video_on    <= video_nxt;
      pixel_x     <= px_nxt;
      pixel_y     <= py_nxt;
      line_start  <= ls_nxt;
      frame_start <= fs_nxt;
    end
  end

endmodule

// File: tb/tb_vga_sync_gen.sv
// tb_vga_sync_gen: scoreboard bench for vga_sync_gen.
// Vertical timing is shrunk to 6+2+2+3 lines so whole frames fit.
module tb_vga_sync_gen;

  logic       clk25 = 1'b0;
  logic       reset_n = 1'b1;
  logic       locked = 1'b0;
  logic       hsync;
  logic       vsync;
  logic       video_on;
  logic [9:0] pixel_x;
  logic [9:0] pixel_y;
  logic       line_start;
  logic       frame_start;

  vga_sync_gen #(
    .V_ACTIVE(6),
    .V_FP    (2),
    .V_SYNC  (2),
    .V_BP    (3)
  ) dut (
    .clk25      (clk25),
    .reset_n    (reset_n),
    .locked     (locked),
    .hsync      (hsync),
    .vsync      (vsync),
    .video_on   (video_on),
    .pixel_x    (pixel_x),
    .pixel_y    (pixel_y),
    .line_start (line_start),
    .frame_start(frame_start)
  );

  always #20 clk25 = ~clk25;

  int edge_n = 0;
  always @(posedge clk25) edge_n <= edge_n + 1;

  typedef struct {
    int         e;
    string      tag;
    logic       hs;
    logic       vs;
    logic       von;
    logic [9:0] px;
    logic [9:0] py;
    logic       ls;
    logic       fs;
  } exp_t;

  exp_t q[$];
  exp_t x;
  int   tests = 0;
  int   fails = 0;

  task automatic push(input int e, input string tag,
                      input logic hs, input logic vs, input logic von,
                      input logic [9:0] px, input logic [9:0] py,
                      input logic ls, input logic fs);
    exp_t t;
    t.e = e; t.tag = tag; t.hs = hs; t.vs = vs; t.von = von;
    t.px = px; t.py = py; t.ls = ls; t.fs = fs;
    q.push_back(t);
  endtask

  task automatic push_idle(input int e, input string tag);
    push(e, tag, 1, 1, 0, 10'd0, 10'd0, 0, 0);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk25);
    #1;
  endtask

  task automatic check_int(input string tag, input int got, input int want);
    tests++;
    if (got != want) begin
      fails++;
      $display("FAIL %s: got %0d, want %0d", tag, got, want);
    end
  endtask

  // first-frame statistics gathered by the monitor
  int f0 = -1;
  int fs_e[$];
  int vs_cnt = 0;
  int hs_cnt = 0;
  int ls_cnt = 0;
  int von_cnt = 0;
  int py_max = 0;

  always @(negedge clk25) begin
    while (q.size() > 0 && q[0].e < edge_n) begin
      x = q.pop_front();
      tests++;
      fails++;
      $display("FAIL %s: edge %0d passed unchecked", x.tag, x.e);
    end
    if (q.size() > 0 && q[0].e == edge_n) begin
      x = q.pop_front();
      tests++;
      if ({hsync, vsync, video_on, pixel_x, pixel_y, line_start, frame_start}
          !== {x.hs, x.vs, x.von, x.px, x.py, x.ls, x.fs}) begin
        fails++;
        $display("FAIL %s @%0d: got hs=%b vs=%b von=%b x=%0d y=%0d ls=%b fs=%b, want hs=%b vs=%b von=%b x=%0d y=%0d ls=%b fs=%b",
                 x.tag, edge_n, hsync, vsync, video_on, pixel_x, pixel_y,
                 line_start, frame_start, x.hs, x.vs, x.von, x.px, x.py,
                 x.ls, x.fs);
      end
    end
    if (frame_start === 1'b1) fs_e.push_back(edge_n);
    if (f0 >= 0 && edge_n >= f0 && edge_n < f0 + 10400) begin
      if (vsync === 1'b0) vs_cnt++;
      if (hsync === 1'b0) hs_cnt++;
      if (line_start === 1'b1) ls_cnt++;
      if (video_on === 1'b1) von_cnt++;
      if (int'(pixel_y) > py_max) py_max = int'(pixel_y);
    end
  end

  int p, d, qe, f2, r, t;

  initial begin
    push_idle(1, "rst_idle1");
    push_idle(2, "rst_idle2");
    push_idle(5, "wait_idle5");
    push_idle(50, "wait_idle50");
    push_idle(103, "wait_idle103");
    #5 reset_n = 1'b0;
    step(3);
    reset_n = 1'b1;
    step(100);

    p = edge_n;
    push_idle(p + 2, "lock_k1");
    push_idle(p + 3, "lock_k2");
    f0 = p + 4;
    push(f0 + 0,     "first_fs",  1, 1, 1, 10'd0,   10'd0, 1, 1);
    push(f0 + 1,     "px1",       1, 1, 1, 10'd1,   10'd0, 0, 0);
    push(f0 + 639,   "px639",     1, 1, 1, 10'd639, 10'd0, 0, 0);
    push(f0 + 640,   "hblank",    1, 1, 0, 10'd0,   10'd0, 0, 0);
    push(f0 + 655,   "pre_hs",    1, 1, 0, 10'd0,   10'd0, 0, 0);
    push(f0 + 656,   "hs_on",     0, 1, 0, 10'd0,   10'd0, 0, 0);
    push(f0 + 751,   "hs_last",   0, 1, 0, 10'd0,   10'd0, 0, 0);
    push(f0 + 752,   "hs_off",    1, 1, 0, 10'd0,   10'd0, 0, 0);
    push(f0 + 799,   "h799",      1, 1, 0, 10'd0,   10'd0, 0, 0);
    push(f0 + 800,   "line1",     1, 1, 1, 10'd0,   10'd1, 1, 0);
    push(f0 + 4639,  "last_vis",  1, 1, 1, 10'd639, 10'd5, 0, 0);
    push(f0 + 4800,  "vblank",    1, 1, 0, 10'd0,   10'd0, 1, 0);
    push(f0 + 6399,  "pre_vs",    1, 1, 0, 10'd0,   10'd0, 0, 0);
    push(f0 + 6400,  "vs_on",     1, 0, 0, 10'd0,   10'd0, 1, 0);
    push(f0 + 7056,  "hs_vs",     0, 0, 0, 10'd0,   10'd0, 0, 0);
    push(f0 + 7999,  "vs_last",   1, 0, 0, 10'd0,   10'd0, 0, 0);
    push(f0 + 8000,  "vs_off",    1, 1, 0, 10'd0,   10'd0, 1, 0);
    push(f0 + 10399, "frame_end", 1, 1, 0, 10'd0,   10'd0, 0, 0);
    push(f0 + 10400, "fs2",       1, 1, 1, 10'd0,   10'd0, 1, 1);
    push(f0 + 10401, "fs2_px1",   1, 1, 1, 10'd1,   10'd0, 0, 0);

    d = f0 + 13100;
    push(d,     "drop_at",   1, 1, 1, 10'd300, 10'd3, 0, 0);
    push(d + 3, "drop_late", 1, 1, 1, 10'd303, 10'd3, 0, 0);
    push_idle(d + 4, "drop_idle");
    push_idle(d + 5, "drop_idle2");
    locked = 1'b1;

    step(d - edge_n);
    locked = 1'b0;
    step(6);
    qe = edge_n;
    push_idle(qe + 3, "relock_k2");
    f2 = qe + 4;
    push(f2,     "relock_fs",  1, 1, 1, 10'd0, 10'd0, 1, 1);
    push(f2 + 1, "relock_px1", 1, 1, 1, 10'd1, 10'd0, 0, 0);
    locked = 1'b1;

    r = f2 + 3300;
    push_idle(r,     "async_rst");
    push_idle(r + 1, "rst_hold1");
    push_idle(r + 2, "rst_hold2");
    step(r - edge_n);
    #4 reset_n = 1'b0;
    step(3);
    t = edge_n;
    push_idle(t + 3, "rel_k2");
    push(t + 4, "rel_fs",  1, 1, 1, 10'd0, 10'd0, 1, 1);
    push(t + 5, "rel_px1", 1, 1, 1, 10'd1, 10'd0, 0, 0);
    reset_n = 1'b1;
    step(10);

    check_int("fs_period", (fs_e.size() >= 2) ? fs_e[1] - fs_e[0] : -1, 10400);
    check_int("vsync_cycles", vs_cnt, 1600);
    check_int("hsync_cycles", hs_cnt, 1248);
    check_int("line_starts", ls_cnt, 13);
    check_int("visible_cycles", von_cnt, 3840);
    check_int("pixel_y_max", py_max, 5);
    check_int("sb_drained", q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
